uart_tx: RTL and testbench
==========================

Name:
uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the receive path and its baud counter.
- Serialises one parallel byte into a frame: start bit (0), DATA LSB-first, optional parity, one stop bit (1).
- Uses the same bit-period timing as the receiver, from an internal down-counting baud timer.
- Sits between the host/register interface and the tx pin; tx idles high.

Parameters:
- BIT_COUNT, 10416, clocks per bit period (100 MHz / 9600 baud); legal range 2..16383.
- PARITY_EN, 0, 1 = insert parity bit after data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send tx_data; honoured only in IDLE.
- tx_data  input  8  byte to send; sampled on the accepting edge only.
- tx  output  1  serial line; 1 when idle.
- tx_busy  output  1  high from the cycle after acceptance until the frame completes.
- tx_done  output  1  one-cycle pulse when the stop bit finishes.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high at an edge:
  - state = IDLE, tx = 1, tx_busy = 0, tx_done = 0;
  - baud timer = 0, bit index = 0, shift register = 0.
  - rst overrides every other input, including mid-frame; tx returns to 1 on that edge and the partial frame is abandoned.
- States: IDLE, START, DATA, PARITY, STOP.
- Baud timer:
  - 14-bit register, counts down.
  - Loaded with BIT_COUNT-1 on entry to every bit state.
  - Decrements each cycle; a bit ends at the edge where the timer == 0.
  - Every bit, including start and stop, is driven for exactly BIT_COUNT cycles.
- IDLE:
  - tx = 1, tx_busy = 0.
  - Edge with tx_start = 1: latch tx_data into the shift register, compute parity, load the timer, go to START.
  - Level-sensitive: a tx_start held high starts a new frame on every IDLE edge.
- START: tx = 0, tx_busy = 1. At timer == 0: go to DATA, bit index = 0, reload the timer.
- DATA:
  - tx = shift register bit 0.
  - At timer == 0: shift right, bit index + 1, reload the timer.
  - After bit index 7 completes: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - tx = (^latched data) XOR PARITY_ODD.
  - At timer == 0: go to STOP, reload the timer.
- STOP:
  - tx = 1.
  - At timer == 0: go to IDLE, set tx_done = 1 for exactly one cycle, tx_busy = 0 in that same cycle.
- tx is a registered output: no glitches, and it changes only on bit boundaries.
- Latency from the accepting edge:
  - tx falls in the next cycle.
  - tx_done asserts 10*BIT_COUNT cycles later, or 11*BIT_COUNT with parity.
- Busy behaviour:
  - tx_start while tx_busy = 1 is ignored; no queuing.
  - Changes on tx_data while busy do not affect the frame in flight.
- Back-to-back frames:
  - tx_start high during the tx_done cycle is accepted at the next edge, since the FSM is already in IDLE.
  - Minimum spacing is therefore one idle-high cycle between frames.
- tx_done is never high while tx_busy = 1.

Test Plan:
- Reset: assert rst for 3 cycles with tx_start = 1 -> tx = 1, tx_busy = 0, tx_done = 0 throughout; no frame starts while rst is high.
- Single frame: BIT_COUNT = 16, PARITY_EN = 0, tx_data = 0x55, one-cycle tx_start -> tx sequence is 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles. tx_busy is high for 160 cycles. tx_done pulses once, at cycle 160 after acceptance.
- Busy rejection: during the frame for 0xA3, pulse tx_start with tx_data = 0xFF -> the line still shows 0xA3 (bits 1,1,0,0,0,1,0,1 LSB-first). No second frame follows.
- Back-to-back: hold tx_start = 1, tx_data = 0x0F -> two consecutive frames separated by exactly one idle-high cycle. tx_done pulses at cycles 160 and 321.
- Parity: PARITY_EN = 1, tx_data = 0x01 -> parity bit = 1 with PARITY_ODD = 0 and 0 with PARITY_ODD = 1. Frame lasts 176 cycles (BIT_COUNT = 16).
- Reset mid-frame: assert rst during data bit 3 -> tx = 1 and tx_busy = 0 after that edge, with no tx_done. A new tx_start after reset sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (start, LSB-first data, optional parity, stop); ports clk, rst, tx_start, tx_data[7:0] in; tx, tx_busy, tx_done out
module uart_tx #(
  parameter int BIT_COUNT  = 10416,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [13:0] RELOAD = 14'(BIT_COUNT - 1);
  state_t      state_q;
  logic [13:0] timer_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end;
  assign bit_end = timer_q == 14'd0;
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) timer_q <= bit_end ? RELOAD : timer_q - 14'd1;
      case (state_q)
        IDLE: if (tx_start) begin
          shift_q <= tx_data;
          par_q   <= ^tx_data ^ PARITY_ODD;
          timer_q <= RELOAD;
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          idx_q   <= '0;
          tx_q    <= shift_q[0];
        end
        DATA: if (bit_end) begin
          shift_q <= shift_q >> 1;
          idx_q   <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_q <= PARITY_EN ? PARITY : STOP;
            tx_q    <= PARITY_EN ? par_q : 1'b1;
          end else begin
            tx_q <= shift_q[1];
          end
        end
        PARITY: if (bit_end) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (bit_end) begin
          state_q <= IDLE;
          timer_q <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed plus random frames on no-parity, even and odd parity instances checked cycle by cycle against a frame model
module tb_uart_tx;
  localparam int BC = 16;
  logic       clk = 1'b0;
  logic       rst;
  logic       start [3];
  logic [7:0] data  [3];
  logic       tx_w  [3];
  logic       busy_w[3];
  logic       done_w[3];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(.BIT_COUNT(BC), .PARITY_EN(1'(g > 0)), .PARITY_ODD(1'(g == 2))) u_dut (
      .clk(clk),
      .rst(rst),
      .tx_start(start[g]),
      .tx_data(data[g]),
      .tx(tx_w[g]),
      .tx_busy(busy_w[g]),
      .tx_done(done_w[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input int u, input string tag, input logic done_exp);
    chk({tag, " tx"}, 32'(tx_w[u]), 32'd1);
    chk({tag, " busy"}, 32'(busy_w[u]), 32'd0);
    chk({tag, " done"}, 32'(done_w[u]), 32'(done_exp));
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("idle u%0d c%0d", u, i), 1'b0);
    end
  endtask
  // Starts a frame at the next edge and checks every cycle of it; poke re-requests with 0xFF mid-frame,
  // hold keeps tx_start high throughout, rk asserts rst at that cycle and abandons the frame.
  task automatic run_frame(input int u, input logic [7:0] d, input bit hold, input int poke, input int rk);
    logic q[$];
    int   n;
    q = {1'b0};
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (u > 0) q.push_back(1'(($countones(d) % 2) == 1) ^ (u == 2));
    q.push_back(1'b1);
    n = q.size() * BC;
    start[u] = 1'b1;
    data[u]  = d;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d d%0h tx k%0d", u, d, k), 32'(tx_w[u]), 32'(q[(k - 1) / BC]));
      chk($sformatf("u%0d d%0h busy k%0d", u, d, k), 32'(busy_w[u]), 32'd1);
      chk($sformatf("u%0d d%0h done k%0d", u, d, k), 32'(done_w[u]), 32'd0);
      if (k == rk) begin
        rst = 1'b1;
        @(negedge clk);
        chk_idle(u, $sformatf("u%0d midrst", u), 1'b0);
        rst = 1'b0;
        return;
      end
      if (!hold) begin
        start[u] = (k == poke);
        data[u]  = (k == poke) ? 8'hFF : 8'($urandom);
      end
    end
    @(negedge clk);
    chk_idle(u, $sformatf("u%0d d%0h end", u, d), 1'b1);
  endtask
  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b1;
      data[u]  = 8'h5A;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("reset u%0d c%0d", u, c), 1'b0);
    end
    rst = 1'b0;
    for (int u = 0; u < 3; u++) start[u] = 1'b0;
    idle_cycles(2);
    run_frame(0, 8'h55, 1'b0, 0, 0);
    idle_cycles(3);
    run_frame(0, 8'hA3, 1'b0, 40, 0);
    idle_cycles(BC * 2);
    run_frame(0, 8'h0F, 1'b1, 0, 0);
    run_frame(0, 8'h0F, 1'b0, 0, 0);
    idle_cycles(3);
    run_frame(1, 8'h01, 1'b0, 0, 0);
    idle_cycles(2);
    run_frame(2, 8'h01, 1'b0, 0, 0);
    idle_cycles(2);
    for (int r = 0; r < 2; r++)
      for (int u = 0; u < 3; u++) begin
        run_frame(u, 8'($urandom), 1'b0, (r == 1) ? int'($urandom_range(2, 150)) : 0, 0);
        idle_cycles(BC + 2);
      end
    run_frame(0, 8'hC6, 1'b0, 0, 4 * BC + 6);
    idle_cycles(BC * 3);
    run_frame(0, 8'($urandom), 1'b0, 0, 0);
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
